vz16_fetch_queue: RTL and testbench



---
 rtl/vz16_pkg.sv | 24 ++
 rtl/vz16_fq_ram2w1r.sv | 50 +++++
 rtl/vz16_fetch_queue.sv | 141 ++++++++++++++
 tb/tb_vz16_fetch_queue.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vz16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vz16_pkg
// Description : Shared VZ16 front-end types and constants. The fetch-queue
//               entry type is also consumed by the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vz16_pkg;

    localparam int VZ16_INST_W = 16;
    localparam int VZ16_PC_W   = 16;

    typedef struct packed {
        logic [VZ16_INST_W-1:0] inst;
        logic [VZ16_PC_W-1:0]   pc;
    } vz16_fq_entry_t;

    // Number of set bits in a two-slot fetch mask (0, 1 or 2).
    function automatic logic [1:0] vz16_popcount2(input logic [1:0] mask);
        return {1'b0, mask[0]} + {1'b0, mask[1]};
    endfunction

endpackage : vz16_pkg
`default_nettype wire

// File: rtl/vz16_fq_ram2w1r.sv
`default_nettype none
// ============================================================================
// Module      : vz16_fq_ram2w1r
// Description : DEPTH x entry register file for the fetch queue.
//               Two synchronous write ports, one asynchronous read port.
// Ports       : clk, rst_n           - clock, async active-low reset
//               i_wrEn0/Addr0/Data0  - first write port (lower slot)
//               i_wrEn1/Addr1/Data1  - second write port (upper slot)
//               i_rdAddr, o_rdData   - combinational read port
// Revision    : 1.0 - initial release
// ============================================================================
module vz16_fq_ram2w1r
    import vz16_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wrEn0,
    input  logic [$clog2(DEPTH)-1:0]   i_wrAddr0,
    input  vz16_fq_entry_t             i_wrData0,
    input  logic                       i_wrEn1,
    input  logic [$clog2(DEPTH)-1:0]   i_wrAddr1,
    input  vz16_fq_entry_t             i_wrData1,
    input  logic [$clog2(DEPTH)-1:0]   i_rdAddr,
    output vz16_fq_entry_t             o_rdData
);

    vz16_fq_entry_t r_mem [DEPTH];

    // The two write addresses are always consecutive, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_wrEn0) begin
                r_mem[i_wrAddr0] <= i_wrData0;
            end
            if (i_wrEn1) begin
                r_mem[i_wrAddr1] <= i_wrData1;
            end
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule : vz16_fq_ram2w1r
`default_nettype wire

// File: rtl/vz16_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : vz16_fetch_queue
// Description : Two-in / one-out instruction fetch queue in front of the
//               VZ16 decoder. Buffers up to DEPTH (inst, pc) entries in
//               program order and drops everything on i_flush.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               i_flush                       - discard all entries
//               i_fetch_valid/word/mask/pc    - fetch-side push (2 slots)
//               o_fetch_ready                 - >= 2 entries free
//               o_inst_valid/o_inst/o_pc      - head entry to decoder
//               i_dec_ready                   - decoder consumes head
//               o_count                       - current occupancy
// Options     : VZ16_FQ_BYPASS_EN - when defined, an empty queue forwards the
//               lowest valid fetch slot to the decoder in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vz16_fetch_queue
    import vz16_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_fetch_valid,
    input  logic [31:0]              i_fetch_word,
    input  logic [1:0]               i_fetch_mask,
    input  logic [15:0]              i_fetch_pc,
    output logic                     o_fetch_ready,
    output logic                     o_inst_valid,
    output logic [15:0]              o_inst,
    output logic [15:0]              o_pc,
    input  logic                     i_dec_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam logic [c_PTR_W-1:0] c_READY_MAX = c_PTR_W'(DEPTH - 2);

    // Pointers carry one extra bit so that wrPtr - rdPtr spans 0..DEPTH.
    logic [c_PTR_W-1:0]  r_wrPtr;
    logic [c_PTR_W-1:0]  r_rdPtr;
    logic [c_PTR_W-1:0]  w_count;

    vz16_fq_entry_t      w_slot0;
    vz16_fq_entry_t      w_slot1;
    vz16_fq_entry_t      w_port0Data;
    vz16_fq_entry_t      w_head;

    logic                w_notEmpty;
    logic                w_ready;
    logic                w_pushFire;
    logic                w_popFire;
    logic                w_bypassTake;
    logic [1:0]          w_pushMask;
    logic [1:0]          w_wrMask;
    logic [1:0]          w_nWrite;
    logic                w_wrEn0;
    logic                w_wrEn1;
    logic [c_ADDR_W-1:0] w_wrAddr0;
    logic [c_ADDR_W-1:0] w_wrAddr1;

    assign w_count    = r_wrPtr - r_rdPtr;
    assign w_notEmpty = (w_count != '0);
    assign w_ready    = (w_count <= c_READY_MAX);

    assign w_slot0 = '{inst: i_fetch_word[15:0],  pc: i_fetch_pc};
    assign w_slot1 = '{inst: i_fetch_word[31:16], pc: i_fetch_pc + 16'd1};

    assign w_pushFire = i_fetch_valid && w_ready;
    assign w_pushMask = w_pushFire ? i_fetch_mask : 2'b00;
    // Pops only ever come out of storage; a bypassed slot is never stored.
    assign w_popFire  = w_notEmpty && i_dec_ready;

`ifdef VZ16_FQ_BYPASS_EN
    vz16_fq_entry_t w_firstSlot;
    logic           w_bypass;

    assign w_firstSlot  = i_fetch_mask[0] ? w_slot0 : w_slot1;
    assign w_bypass     = !w_notEmpty && w_pushFire && (i_fetch_mask != 2'b00) && !i_flush;
    assign w_bypassTake = w_bypass && i_dec_ready;
`else
    assign w_bypassTake = 1'b0;
`endif

    // A consumed bypass removes the lowest valid slot from what gets stored.
    assign w_wrMask = w_bypassTake ? (w_pushMask & (w_pushMask - 2'b01)) : w_pushMask;
    assign w_nWrite = vz16_popcount2(w_wrMask);

    // Valid slots are compacted: the first one lands at wrPtr, the second at wrPtr+1.
    assign w_port0Data = w_wrMask[0] ? w_slot0 : w_slot1;
    assign w_wrEn0     = (w_nWrite != 2'd0) && !i_flush;
    assign w_wrEn1     = (w_nWrite == 2'd2) && !i_flush;
    assign w_wrAddr0   = r_wrPtr[c_ADDR_W-1:0];
    assign w_wrAddr1   = w_wrAddr0 + c_ADDR_W'(1);

    vz16_fq_ram2w1r #(
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wrEn0   (w_wrEn0),
        .i_wrAddr0 (w_wrAddr0),
        .i_wrData0 (w_port0Data),
        .i_wrEn1   (w_wrEn1),
        .i_wrAddr1 (w_wrAddr1),
        .i_wrData1 (w_slot1),
        .i_rdAddr  (r_rdPtr[c_ADDR_W-1:0]),
        .o_rdData  (w_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            r_wrPtr <= r_wrPtr + c_PTR_W'(w_nWrite);
            r_rdPtr <= r_rdPtr + c_PTR_W'(w_popFire);
        end
    end

    assign o_fetch_ready = w_ready;
    assign o_count       = w_count;

`ifdef VZ16_FQ_BYPASS_EN
    assign o_inst_valid = w_notEmpty || w_bypass;
    assign o_inst       = w_bypass ? w_firstSlot.inst : w_head.inst;
    assign o_pc         = w_bypass ? w_firstSlot.pc   : w_head.pc;
`else
    assign o_inst_valid = w_notEmpty;
    assign o_inst       = w_head.inst;
    assign o_pc         = w_head.pc;
`endif

endmodule : vz16_fetch_queue
`default_nettype wire

// File: tb/tb_vz16_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_vz16_fetch_queue
// Description : Directed self-checking bench for vz16_fetch_queue (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vz16_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        fetchValid;
    logic [31:0] fetchWord;
    logic [1:0]  fetchMask;
    logic [15:0] fetchPc;
    logic        fetchReady;
    logic        instValid;
    logic [15:0] inst;
    logic [15:0] pc;
    logic        decReady;
    logic [3:0]  count;

    int numChecks = 0;
    int numFails  = 0;

    always #5 clk = ~clk;

    vz16_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (flush),
        .i_fetch_valid (fetchValid),
        .i_fetch_word  (fetchWord),
        .i_fetch_mask  (fetchMask),
        .i_fetch_pc    (fetchPc),
        .o_fetch_ready (fetchReady),
        .o_inst_valid  (instValid),
        .o_inst        (inst),
        .o_pc          (pc),
        .i_dec_ready   (decReady),
        .o_count       (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; fetchValid = 0; fetchMask = 0;
        fetchWord = '0; fetchPc = '0; decReady = 0;
        repeat (2) step();
        numChecks++;
        if ({fetchReady, instValid, inst, pc, count} !== {1'b1, 1'b0, 16'h0, 16'h0, 4'd0}) begin
            numFails++;
            $display("FAIL reset_state: got rdy=%b vld=%b inst=%h pc=%h cnt=%0d, want 1 0 0000 0000 0",
                     fetchReady, instValid, inst, pc, count);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        fetchValid = 1; fetchWord = 32'h2222_1111; fetchMask = 2'b11; fetchPc = 16'h0100; decReady = 1;
        step();
        fetchValid = 0; fetchMask = 0;
        numChecks++;
        if ({instValid, inst, pc, count} !== {1'b1, 16'h1111, 16'h0100, 4'd2}) begin
            numFails++;
            $display("FAIL basic_first: got vld=%b inst=%h pc=%h cnt=%0d, want 1 1111 0100 2", instValid, inst, pc, count);
        end
        step();
        numChecks++;
        if ({instValid, inst, pc, count} !== {1'b1, 16'h2222, 16'h0101, 4'd1}) begin
            numFails++;
            $display("FAIL basic_second: got vld=%b inst=%h pc=%h cnt=%0d, want 1 2222 0101 1", instValid, inst, pc, count);
        end
        step();
        numChecks++;
        if ({instValid, count} !== {1'b0, 4'd0}) begin
            numFails++;
            $display("FAIL basic_empty: got vld=%b cnt=%0d, want 0 0", instValid, count);
        end
        decReady = 0;
    endtask

    task automatic test_slot1_only();
        fetchValid = 1; fetchWord = 32'hBEEF_0000; fetchMask = 2'b10; fetchPc = 16'h0200; decReady = 0;
        step();
        fetchValid = 0; fetchMask = 0;
        numChecks++;
        if ({instValid, inst, pc, count} !== {1'b1, 16'hBEEF, 16'h0201, 4'd1}) begin
            numFails++;
            $display("FAIL slot1_only: got vld=%b inst=%h pc=%h cnt=%0d, want 1 beef 0201 1", instValid, inst, pc, count);
        end
        // Mask 00 is a no-op push
        fetchValid = 1; fetchMask = 2'b00; fetchPc = 16'h0210;
        step();
        fetchValid = 0;
        numChecks++;
        if ({count, pc} !== {4'd1, 16'h0201}) begin
            numFails++;
            $display("FAIL mask00_noop: got cnt=%0d pc=%h, want 1 0201", count, pc);
        end
        decReady = 1;
        step();
        decReady = 0;
        numChecks++;
        if (count !== 4'd0) begin
            numFails++;
            $display("FAIL slot1_drain: got cnt=%0d, want 0", count);
        end
    endtask

    task automatic test_full();
        int expCount;
        decReady = 0;
        for (int k = 0; k < 5; k++) begin
            fetchValid = 1; fetchMask = 2'b11;
            fetchPc   = 16'h1000 + 16'(2 * k);
            fetchWord = {16'hA001 + 16'(2 * k), 16'hA000 + 16'(2 * k)};
            step();
            expCount = (2 * k + 2 > DEPTH) ? DEPTH : 2 * k + 2;
            numChecks++;
            if ({count, fetchReady} !== {4'(expCount), (expCount <= DEPTH - 2)}) begin
                numFails++;
                $display("FAIL full_fill[%0d]: got cnt=%0d rdy=%b, want %0d %b", k, count, fetchReady,
                         expCount, (expCount <= DEPTH - 2));
            end
        end
        fetchValid = 0; fetchMask = 0; decReady = 1;
        for (int j = 0; j < DEPTH; j++) begin
            numChecks++;
            if ({instValid, pc, inst} !== {1'b1, 16'h1000 + 16'(j), 16'hA000 + 16'(j)}) begin
                numFails++;
                $display("FAIL full_drain[%0d]: got vld=%b pc=%h inst=%h, want 1 %h %h", j, instValid, pc, inst,
                         16'h1000 + 16'(j), 16'hA000 + 16'(j));
            end
            step();
        end
        decReady = 0;
        numChecks++;
        if ({instValid, count, fetchReady} !== {1'b0, 4'd0, 1'b1}) begin
            numFails++;
            $display("FAIL full_after_drain: got vld=%b cnt=%0d rdy=%b, want 0 0 1", instValid, count, fetchReady);
        end
        // Occupancy 7 must also block pushes
        for (int k = 0; k < 4; k++) begin
            fetchValid = 1; fetchMask = (k == 3) ? 2'b01 : 2'b11;
            fetchPc   = 16'h1100 + 16'(2 * k);
            fetchWord = {16'hB001 + 16'(2 * k), 16'hB000 + 16'(2 * k)};
            step();
        end
        numChecks++;
        if ({count, fetchReady} !== {4'd7, 1'b0}) begin
            numFails++;
            $display("FAIL count7_ready: got cnt=%0d rdy=%b, want 7 0", count, fetchReady);
        end
        fetchMask = 2'b11; fetchPc = 16'h2000; fetchWord = 32'hDEAD_DEAD;
        step();
        fetchValid = 0; fetchMask = 0;
        numChecks++;
        if (count !== 4'd7) begin
            numFails++;
            $display("FAIL count7_reject: got cnt=%0d, want 7", count);
        end
        decReady = 1;
        for (int j = 0; j < 7; j++) begin
            numChecks++;
            if ({instValid, pc} !== {1'b1, 16'h1100 + 16'(j)}) begin
                numFails++;
                $display("FAIL count7_drain[%0d]: got vld=%b pc=%h, want 1 %h", j, instValid, pc, 16'h1100 + 16'(j));
            end
            step();
        end
        decReady = 0;
    endtask

    task automatic test_wrap();
        logic [15:0] q[$];
        logic [15:0] nextPc;
        logic [1:0]  mask;
        int          pushed;
        int          cyc;
        bit          doPush;
        bit          willPush;
        bit          willPop;
        nextPc = 16'hFFF0; pushed = 0; cyc = 0;
        while ((pushed < 3 * DEPTH + 6 || q.size() != 0) && cyc < 400) begin
            numChecks++;
            if ({count, instValid, fetchReady} !== {4'(q.size()), (q.size() != 0), (DEPTH - q.size() >= 2)}) begin
                numFails++;
                $display("FAIL wrap_state[%0d]: got cnt=%0d vld=%b rdy=%b, want cnt=%0d", cyc, count, instValid,
                         fetchReady, q.size());
            end
            if (q.size() != 0) begin
                numChecks++;
                if ({pc, inst} !== {q[0], q[0] ^ 16'h5A5A}) begin
                    numFails++;
                    $display("FAIL wrap_head[%0d]: got pc=%h inst=%h, want %h %h", cyc, pc, inst, q[0], q[0] ^ 16'h5A5A);
                end
            end
            doPush     = (pushed < 3 * DEPTH + 6);
            mask       = 2'($urandom_range(0, 3));
            fetchValid = doPush;
            fetchMask  = mask;
            fetchPc    = nextPc;
            fetchWord  = {(nextPc + 16'd1) ^ 16'h5A5A, nextPc ^ 16'h5A5A};
            decReady   = ($urandom_range(0, 3) != 0);
            willPop    = (q.size() != 0) && decReady;
            willPush   = doPush && (DEPTH - q.size() >= 2);
            step();
            if (willPop) void'(q.pop_front());
            if (willPush) begin
                if (mask[0]) begin q.push_back(nextPc); pushed++; end
                if (mask[1]) begin q.push_back(nextPc + 16'd1); pushed++; end
                nextPc = nextPc + 16'd2;
            end
            cyc++;
        end
        fetchValid = 0; fetchMask = 0; decReady = 0;
        numChecks++;
        if (cyc >= 400 || count !== 4'd0) begin
            numFails++;
            $display("FAIL wrap_complete: got cycles=%0d cnt=%0d pushed=%0d, want <400 0", cyc, count, pushed);
        end
    endtask

    task automatic test_flush();
        decReady = 0;
        for (int k = 0; k < 3; k++) begin
            fetchValid = 1; fetchMask = (k == 2) ? 2'b01 : 2'b11;
            fetchPc = 16'h0500 + 16'(2 * k); fetchWord = 32'h5555_5555;
            step();
        end
        numChecks++;
        if (count !== 4'd5) begin
            numFails++;
            $display("FAIL flush_fill: got cnt=%0d, want 5", count);
        end
        flush = 1; fetchValid = 1; fetchMask = 2'b11; fetchPc = 16'h0600; decReady = 1;
        step();
        flush = 0; fetchValid = 0; fetchMask = 0; decReady = 0;
        numChecks++;
        if ({count, instValid, fetchReady} !== {4'd0, 1'b0, 1'b1}) begin
            numFails++;
            $display("FAIL flush_clear: got cnt=%0d vld=%b rdy=%b, want 0 0 1", count, instValid, fetchReady);
        end
        fetchValid = 1; fetchMask = 2'b01; fetchPc = 16'h0300; fetchWord = 32'h0000_3333;
        step();
        fetchValid = 0; fetchMask = 0;
        numChecks++;
        if ({instValid, pc, inst, count} !== {1'b1, 16'h0300, 16'h3333, 4'd1}) begin
            numFails++;
            $display("FAIL flush_refill: got vld=%b pc=%h inst=%h cnt=%0d, want 1 0300 3333 1", instValid, pc, inst, count);
        end
        decReady = 1;
        step();
        decReady = 0;
    endtask

    task automatic test_async_reset();
        fetchValid = 1; fetchMask = 2'b11; fetchPc = 16'h0700; fetchWord = 32'h7777_7777;
        step();
        fetchValid = 0; fetchMask = 0;
        numChecks++;
        if (count !== 4'd2) begin
            numFails++;
            $display("FAIL areset_pre: got cnt=%0d, want 2", count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        numChecks++;
        if ({fetchReady, instValid, inst, pc, count} !== {1'b1, 1'b0, 16'h0, 16'h0, 4'd0}) begin
            numFails++;
            $display("FAIL areset_now: got rdy=%b vld=%b inst=%h pc=%h cnt=%0d, want 1 0 0000 0000 0",
                     fetchReady, instValid, inst, pc, count);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

`ifdef VZ16_FQ_BYPASS_EN
    task automatic test_bypass();
        fetchValid = 1; fetchMask = 2'b11; fetchPc = 16'h0400; fetchWord = 32'h4401_4400; decReady = 1;
        #1;
        numChecks++;
        if ({instValid, pc, inst} !== {1'b1, 16'h0400, 16'h4400}) begin
            numFails++;
            $display("FAIL bypass_same_cycle: got vld=%b pc=%h inst=%h, want 1 0400 4400", instValid, pc, inst);
        end
        step();
        fetchValid = 0; fetchMask = 0; decReady = 0;
        numChecks++;
        if ({count, pc} !== {4'd1, 16'h0401}) begin
            numFails++;
            $display("FAIL bypass_remaining: got cnt=%0d pc=%h, want 1 0401", count, pc);
        end
        decReady = 1;
        step();
        decReady = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_slot1_only();
        test_full();
        test_wrap();
        test_flush();
        test_async_reset();
`ifdef VZ16_FQ_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule : tb_vz16_fetch_queue
`default_nettype wire
